// File: rtl/decode_process_if.sv
// Image memory read bus between the decoder and the shared image RAM.
//   row, col : pixel address driven by the decoder (master)
//   in_pix   : pixel data for the address presented on the previous cycle
//              (R 23:16, G 15:8, B 7:0), driven by the memory side (slave)
interface decode_process_if;
   logic [5:0]  row;
   logic [5:0]  col;
   logic [23:0] in_pix;

   modport master (output row, output col, input in_pix);
   modport slave  (input row, input col, output in_pix);
endinterface

// File: rtl/decode_process.sv
// decode_process: recovers a hidden string from an encoded 64x64 image.
// Pixels are scanned in raster order; each contributes one base-3 digit
// (G mod 3). Six digits, least significant first, form one character.
// Decoding stops on a NUL character, after MAX_CHARS characters, or when
// the image runs out.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        1-cycle pulse, accepted only in IDLE or DONE
//   pix          image read bus (row/col out, in_pix back one cycle later)
//   char_valid   1-cycle pulse with each decoded character on char_out
//   out_string   decoded characters, char k at [8*k +: 8]
//   str_len      characters decoded, terminator excluded
//   decode_done  high from end of decode until next start or rst
//   decode_err   sticky: a character value exceeded 255
module decode_process #(
   parameter int IMG_DIM        = 64,
   parameter int MAX_CHARS      = 512,
   parameter int TRITS_PER_CHAR = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   decode_process_if.master       pix,
   output logic                   char_valid,
   output logic [7:0]             char_out,
   output logic [8*MAX_CHARS-1:0] out_string,
   output logic [9:0]             str_len,
   output logic                   decode_done,
   output logic                   decode_err
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] EMIT  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [11:0] LAST_PIX = 12'(IMG_DIM * IMG_DIM - 1);

   logic [2:0]  state_reg;
   logic [11:0] ptr_reg;        // next pixel to fetch, raster order
   logic        exhausted_reg;  // the last pixel of the image has been read
   logic [9:0]  acc_reg;
   logic [9:0]  weight_reg;
   logic [2:0]  trit_cnt_reg;
   logic [9:0]  idx_reg;
   logic [5:0]  row_reg;
   logic [5:0]  col_reg;

   logic [1:0]  trit;
   logic [9:0]  acc_next;
   logic [11:0] ptr_next;
   logic [7:0]  emit_char;
   logic        emit_ovf;
   logic        start_ok;
   logic        store_en;
   logic        unused_rb;

   assign pix.row = row_reg;
   assign pix.col = col_reg;

   // Only the green channel carries data; red and blue are ignored.
   assign unused_rb = ^{pix.in_pix[23:16], pix.in_pix[7:0]};
   assign trit      = 2'(pix.in_pix[15:8] % 8'd3);
   assign acc_next  = acc_reg + ({8'd0, trit} * weight_reg);
   assign ptr_next  = ptr_reg + 12'd1;

   // Six trits can reach 728; anything above a byte saturates to 0xFF.
   assign emit_ovf  = (acc_reg > 10'd255);
   assign emit_char = emit_ovf ? 8'hFF : acc_reg[7:0];

   assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign store_en  = (state_reg == EMIT) && (emit_char != 8'd0);

   // One byte register per output slot; each loads when it is the current index.
   generate
      for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_slot
         logic [7:0] slot_reg;
         always_ff @(posedge clk) begin
            if (rst || start_ok)
               slot_reg <= 8'd0;
            else if (store_en && (idx_reg == 10'(gi)))
               slot_reg <= emit_char;
         end
         assign out_string[8*gi +: 8] = slot_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= 12'd0;
         exhausted_reg <= 1'b0;
         acc_reg       <= 10'd0;
         weight_reg    <= 10'd0;
         trit_cnt_reg  <= 3'd0;
         idx_reg       <= 10'd0;
         row_reg       <= 6'd0;
         col_reg       <= 6'd0;
         char_valid    <= 1'b0;
         char_out      <= 8'd0;
         str_len       <= 10'd0;
         decode_done   <= 1'b0;
         decode_err    <= 1'b0;
      end else begin
         char_valid <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  ptr_reg       <= 12'd0;
                  exhausted_reg <= 1'b0;
                  acc_reg       <= 10'd0;
                  weight_reg    <= 10'd1;
                  trit_cnt_reg  <= 3'd0;
                  idx_reg       <= 10'd0;
                  row_reg       <= 6'd0;
                  col_reg       <= 6'd0;
                  str_len       <= 10'd0;
                  decode_done   <= 1'b0;
                  decode_err    <= 1'b0;
                  state_reg     <= FETCH;
               end
            end
            FETCH: state_reg <= READ;
            READ: begin
               acc_reg      <= acc_next;
               weight_reg   <= weight_reg * 10'd3;
               trit_cnt_reg <= trit_cnt_reg + 3'd1;
               ptr_reg      <= ptr_next;
               if (ptr_reg == LAST_PIX)
                  exhausted_reg <= 1'b1;
               if (trit_cnt_reg + 3'd1 == 3'(TRITS_PER_CHAR)) begin
                  state_reg <= EMIT;
               end else if (ptr_reg == LAST_PIX) begin
                  decode_done <= 1'b1;
                  state_reg   <= DONE;
               end else begin
                  // row/col only move when a new fetch begins, so after DONE
                  // they still show the last pixel actually read.
                  row_reg   <= ptr_next[11:6];
                  col_reg   <= ptr_next[5:0];
                  state_reg <= FETCH;
               end
            end
            EMIT: begin
               char_valid <= 1'b1;
               char_out   <= emit_char;
               if (emit_ovf)
                  decode_err <= 1'b1;
               if (emit_char == 8'd0) begin
                  str_len     <= idx_reg;
                  decode_done <= 1'b1;
                  state_reg   <= DONE;
               end else begin
                  idx_reg <= idx_reg + 10'd1;
                  str_len <= idx_reg + 10'd1;
                  if ((idx_reg + 10'd1 == 10'(MAX_CHARS)) || exhausted_reg) begin
                     decode_done <= 1'b1;
                     state_reg   <= DONE;
                  end else begin
                     acc_reg      <= 10'd0;
                     weight_reg   <= 10'd1;
                     trit_cnt_reg <= 3'd0;
                     row_reg      <= ptr_reg[11:6];
                     col_reg      <= ptr_reg[5:0];
                     state_reg    <= FETCH;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_decode_process.sv
module tb_decode_process;
   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          char_valid;
   logic [7:0]    char_out;
   logic [4095:0] out_string;
   logic [9:0]    str_len;
   logic          decode_done;
   logic          decode_err;

   decode_process_if pix ();

   decode_process dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pix         (pix.master),
      .char_valid  (char_valid),
      .char_out    (char_out),
      .out_string  (out_string),
      .str_len     (str_len),
      .decode_done (decode_done),
      .decode_err  (decode_err)
   );

   always #5 clk = ~clk;

   // Image RAM with registered read.
   logic [23:0] img [4096];
   always @(posedge clk) pix.in_pix <= img[{pix.row, pix.col}];

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   logic [7:0] first_char;

   always @(negedge clk) begin
      if (char_valid) begin
         if (pulse_cnt == 0) first_char = char_out;
         pulse_cnt = pulse_cnt + 1;
      end
   end

   typedef struct packed {
      logic [47:0] g;        // G byte of pixel i at [8*i +: 8]
      logic [7:0]  rb;       // R and B value
      logic [7:0]  zg;       // G value used for all following (NUL) pixels
      logic [7:0]  exp_char;
      logic        exp_err;
      logic [9:0]  exp_len;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!decode_done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!decode_done) begin
         errors++;
         $display("FAIL %s: timeout, decode_done got 0 expected 1", name);
      end
      @(negedge clk); #1;
   endtask

   task automatic fill_img(input logic [7:0] rb, input logic [7:0] zg);
      for (int i = 0; i < 4096; i++) img[i] = {rb, zg, rb};
   endtask

   task automatic put_char(input int base, input logic [47:0] g);
      for (int i = 0; i < 6; i++) img[base + i] = {8'h00, g[8*i +: 8], 8'h00};
   endtask

   logic [47:0] pat_a;
   logic [47:0] pat_b;
   logic [47:0] pat_c;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      fill_img(8'h00, 8'h00);
      pat_a = {8'd0, 8'd0, 8'd5, 8'd1, 8'd3, 8'd2};
      pat_b = {8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd0};
      pat_c = {8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1};

      vecs[0] = '{pat_a, 8'h00, 8'h00, 8'h41, 1'b0, 10'd1};
      vecs[1] = '{{8'd255, 8'd255, 8'd5, 8'd1, 8'd255, 8'd2}, 8'hFF, 8'hFF, 8'h41, 1'b0, 10'd1};
      vecs[2] = '{{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 8'h00, 8'h00, 8'hFF, 1'b1, 10'd1};
      vecs[3] = '{{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 8'h00, 8'h00, 8'hFF, 1'b0, 10'd1};
      vecs[4] = '{{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1}, 8'h00, 8'h00, 8'hFF, 1'b1, 10'd1};
      vecs[5] = '{48'd0, 8'h00, 8'h00, 8'h00, 1'b0, 10'd0};
      vecs[6] = '{{8'd6, 8'd13, 8'd10, 8'd7, 8'd4, 8'd200}, 8'h00, 8'h00, 8'h7A, 1'b0, 10'd1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_char_valid", 32'(char_valid), 32'd0);
      chk("rst_char_out", 32'(char_out), 32'd0);
      chk("rst_str_len", 32'(str_len), 32'd0);
      chk("rst_done", 32'(decode_done), 32'd0);
      chk("rst_err", 32'(decode_err), 32'd0);
      chk("rst_row_col", 32'({pix.row, pix.col}), 32'd0);
      chk("rst_out_string", 32'(out_string != '0), 32'd0);
      rst = 1'b0;

      // Table-driven single-character vectors, each followed by a NUL
      for (int v = 0; v < 7; v++) begin
         fill_img(vecs[v].rb, vecs[v].zg);
         for (int i = 0; i < 6; i++) img[i] = {vecs[v].rb, vecs[v].g[8*i +: 8], vecs[v].rb};
         pulse_cnt = 0;
         pulse_start();
         wait_done(200, $sformatf("v%0d_done", v));
         $display("vec %0d: char=%0h len=%0d err=%0b pulses=%0d", v, first_char, str_len, decode_err, pulse_cnt);
         chk($sformatf("v%0d_char", v), 32'(first_char), 32'(vecs[v].exp_char));
         chk($sformatf("v%0d_len", v), 32'(str_len), 32'(vecs[v].exp_len));
         chk($sformatf("v%0d_str0", v), 32'(out_string[7:0]),
             32'((vecs[v].exp_len != 0) ? vecs[v].exp_char : 8'h00));
         chk($sformatf("v%0d_str1", v), 32'(out_string[15:8]), 32'd0);
         chk($sformatf("v%0d_err", v), 32'(decode_err), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_pulses", v), 32'(pulse_cnt), 32'(vecs[v].exp_len) + 32'd1);
      end

      // Timing: 13 cycles from start edge to first char_valid; a start
      // during FETCH must be ignored.
      begin
         int n;
         fill_img(8'h00, 8'h00);
         put_char(0, pat_a);
         @(posedge clk); #1 start = 1'b1;
         @(posedge clk); #1;                 // start sampled here
         chk("t_row_col_fetch", 32'({pix.row, pix.col}), 32'd0);
         @(posedge clk); #1 start = 1'b0;    // second pulse sampled in FETCH
         n = 1;
         while (!char_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         $display("timing: first char_valid after %0d cycles", n);
         chk("t_latency", 32'(n), 32'd13);
         chk("t_char", 32'(char_out), 32'h41);
         wait_done(200, "t_done");
         chk("t_len", 32'(str_len), 32'd1);
      end

      // Full capacity: 'A' everywhere, no NUL
      for (int i = 0; i < 4096; i++) img[i] = {8'h00, pat_a[8*(i % 6) +: 8], 8'h00};
      pulse_cnt = 0;
      pulse_start();
      wait_done(8000, "full_done");
      $display("full: pulses=%0d len=%0d row=%0d col=%0d", pulse_cnt, str_len, pix.row, pix.col);
      chk("full_pulses", 32'(pulse_cnt), 32'd512);
      chk("full_len", 32'(str_len), 32'd512);
      chk("full_row", 32'(pix.row), 32'd47);
      chk("full_col", 32'(pix.col), 32'd63);
      chk("full_err", 32'(decode_err), 32'd0);
      chk("full_last", 32'(out_string[8*511 +: 8]), 32'h41);
      chk("full_mid", 32'(out_string[8*200 +: 8]), 32'h41);

      // Reset during READ of character 3, then a clean restart
      fill_img(8'h00, 8'h00);
      put_char(0, pat_a);
      put_char(6, pat_b);
      put_char(12, pat_c);
      pulse_cnt = 0;
      pulse_start();
      begin
         int n = 0;
         while (pulse_cnt < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk("rm_reach_char3", 32'(pulse_cnt), 32'd2);
      end
      @(posedge clk); #1 rst = 1'b1;         // state is READ of char 3 here
      @(posedge clk); #1 rst = 1'b0;
      chk("rm_char_valid", 32'(char_valid), 32'd0);
      chk("rm_char_out", 32'(char_out), 32'd0);
      chk("rm_len", 32'(str_len), 32'd0);
      chk("rm_row_col", 32'({pix.row, pix.col}), 32'd0);
      chk("rm_out_string", 32'(out_string != '0), 32'd0);
      chk("rm_done_err", 32'({decode_done, decode_err}), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("rm_no_pulse", 32'(pulse_cnt), 32'd2);
      pulse_cnt = 0;
      pulse_start();
      wait_done(300, "rm_restart_done");
      $display("restart: len=%0d str=%0h", str_len, out_string[23:0]);
      chk("rm_restart_len", 32'(str_len), 32'd3);
      chk("rm_restart_str", 32'(out_string[23:0]), 32'h434241);
      chk("rm_restart_first", 32'(first_char), 32'h41);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
